// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_seq_pkg;

   localparam logic [2:0] OPC_ADD = 3'b000;
   localparam logic [2:0] OPC_SUB = 3'b001;
   localparam logic [2:0] OPC_AND = 3'b010;
   localparam logic [2:0] OPC_OR  = 3'b011;
   localparam logic [2:0] OPC_XOR = 3'b100;
   localparam logic [2:0] OPC_SHL = 3'b101;
   localparam logic [2:0] OPC_SHR = 3'b110;
   localparam logic [2:0] OPC_MUL = 3'b111;

   typedef enum logic [2:0] {
      OP_ADD = OPC_ADD,
      OP_SUB = OPC_SUB,
      OP_AND = OPC_AND,
      OP_OR  = OPC_OR,
      OP_XOR = OPC_XOR,
      OP_SHL = OPC_SHL,
      OP_SHR = OPC_SHR,
      OP_MUL = OPC_MUL
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_DONE
   } state_e;

endpackage

// File: rtl/alu_seq_flags.sv
// Combinational status-flag generation from the final result; flag_err reports MUL
// when the multiplier is compiled out (ALU_SEQ_MUL_EN undefined).
module alu_seq_flags
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] result,
   input  logic             carry,
   input  logic             ovf,
   input  op_e              op,
   output logic             flag_zero,
   output logic             flag_neg,
   output logic             flag_carry,
   output logic             flag_ovf,
   output logic             flag_err
);

   assign flag_zero  = (result == '0);
   assign flag_neg   = result[WIDTH-1];
   assign flag_carry = carry;
   assign flag_ovf   = ovf && ((op == OP_ADD) || (op == OP_SUB));
`ifdef ALU_SEQ_MUL_EN
   assign flag_err   = 1'b0;
`else
   assign flag_err   = (op == OP_MUL);
`endif

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, bit-serial shifts, iterative shift-add MUL
// (present only with ALU_SEQ_MUL_EN). Result is held in DONE until out_ready.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_zero,
   output logic             flag_neg,
   output logic             flag_carry,
   output logic             flag_ovf,
   output logic             flag_err
);

   localparam int SHW  = $clog2(WIDTH);
   localparam int CNTW = SHW + 1;

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic              carry_q, carry_d;
   logic              ovf_q, ovf_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
`ifdef ALU_SEQ_MUL_EN
   logic [WIDTH-1:0]  mcand_q, mcand_d;
   logic [WIDTH-1:0]  hi_q, hi_d;
   logic [WIDTH:0]    mul_sum;
`endif

   logic [WIDTH:0]    add_sum, sub_sum;
   logic [SHW-1:0]    shamt;
   logic              fz, fn, fc, fo, fe;

   assign add_sum = {1'b0, a} + {1'b0, b};
   assign sub_sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
   assign shamt   = b[SHW-1:0];

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      res_d   = res_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
`ifdef ALU_SEQ_MUL_EN
      mcand_d = mcand_q;
      hi_d    = hi_q;
      mul_sum = '0;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d    = op_e'(op);
               carry_d = 1'b0;
               ovf_d   = 1'b0;
               state_d = S_DONE;
               case (op_e'(op))
                  OP_ADD: begin
                     res_d   = add_sum[WIDTH-1:0];
                     carry_d = add_sum[WIDTH];
                     ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
                  end
                  OP_SUB: begin
                     res_d   = sub_sum[WIDTH-1:0];
                     carry_d = sub_sum[WIDTH];
                     ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
                  end
                  OP_AND: res_d = a & b;
                  OP_OR:  res_d = a | b;
                  OP_XOR: res_d = a ^ b;
                  OP_SHL, OP_SHR: begin
                     res_d = a;
                     cnt_d = CNTW'(shamt);
                     if (shamt != '0) state_d = S_EXEC;
                  end
                  OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                     // res holds the multiplier and collects the low product half as it shifts down
                     res_d   = b;
                     hi_d    = '0;
                     mcand_d = a;
                     cnt_d   = CNTW'(WIDTH);
                     state_d = S_EXEC;
`else
                     res_d   = '0;
`endif
                  end
                  default: res_d = '0;
               endcase
            end
         end
         S_EXEC: begin
            cnt_d = cnt_q - CNTW'(1);
            if (cnt_q == CNTW'(1)) state_d = S_DONE;
            case (op_q)
               OP_SHL: begin
                  res_d   = {res_q[WIDTH-2:0], 1'b0};
                  carry_d = res_q[WIDTH-1];
               end
               OP_SHR: begin
                  res_d   = {1'b0, res_q[WIDTH-1:1]};
                  carry_d = res_q[0];
               end
`ifdef ALU_SEQ_MUL_EN
               OP_MUL: begin
                  mul_sum = {1'b0, hi_q} + (res_q[0] ? {1'b0, mcand_q} : '0);
                  hi_d    = mul_sum[WIDTH:1];
                  res_d   = {mul_sum[0], res_q[WIDTH-1:1]};
                  carry_d = |mul_sum[WIDTH:1];
               end
`endif
               default: ;
            endcase
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= OP_ADD;
         res_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
`ifdef ALU_SEQ_MUL_EN
         mcand_q <= '0;
         hi_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
`ifdef ALU_SEQ_MUL_EN
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
`endif
      end
   end

   alu_seq_flags #(.WIDTH(WIDTH)) u_flags (
      .result     (res_q),
      .carry      (carry_q),
      .ovf        (ovf_q),
      .op         (op_q),
      .flag_zero  (fz),
      .flag_neg   (fn),
      .flag_carry (fc),
      .flag_ovf   (fo),
      .flag_err   (fe)
   );

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign result     = res_q;
   // Flags only mean something alongside a valid result; keeps them 0 out of reset.
   assign flag_zero  = out_valid & fz;
   assign flag_neg   = out_valid & fn;
   assign flag_carry = out_valid & fc;
   assign flag_ovf   = out_valid & fo;
   assign flag_err   = out_valid & fe;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8; expectations are hand-computed vectors.
module tb_alu_seq;
   import alu_seq_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid;
   logic [W-1:0] result;
   logic         flag_zero, flag_neg, flag_carry, flag_ovf, flag_err;
   logic [4:0]   flg;

   assign flg = {flag_zero, flag_neg, flag_carry, flag_ovf, flag_err};

   alu_seq #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .flag_zero  (flag_zero),
      .flag_neg   (flag_neg),
      .flag_carry (flag_carry),
      .flag_ovf   (flag_ovf),
      .flag_err   (flag_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] res;
      logic [4:0]   flg;
      int           lat;
      int           acc;
   } exp_t;

   typedef struct {
      logic [2:0]   o;
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic [W-1:0] res;
      logic [4:0]   flg;
      int           lat;
   } vec_t;

   exp_t sb[$];
   vec_t vt[$];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: compares each completed output handshake against the scoreboard head.
   logic prev_ov = 1'b0;
   int   first_cyc = 0;
   exp_t e;
   always @(negedge clk) begin
      if (out_valid && !prev_ov) first_cyc = cyc;
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: got result 0x%0h, expected no output", result);
         end else begin
            e = sb.pop_front();
            chk("result", 32'(result), 32'(e.res));
            chk("flags_znco_e", 32'(flg), 32'(e.flg));
            chk("latency", 32'(first_cyc - e.acc + 1), 32'(e.lat));
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] er, input logic [4:0] ef, input int el, input bit push);
      int t;
      t = 0;
      @(posedge clk); #1;
      while (!in_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (!in_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL issue_timeout: in_ready got 0, expected 1");
         return;
      end
      in_valid = 1'b1;
      op = o;
      a = ia;
      b = ib;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = ~ia;
      b = ~ib;
      if (push) sb.push_back('{er, ef, el, cyc});
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((sb.size() != 0 || !in_ready) && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      //          op       a      b      result flags {z,n,c,o,e}  latency
      vt.push_back('{OPC_ADD, 8'h7F, 8'h01, 8'h80, 5'b01010, 1});
      vt.push_back('{OPC_SUB, 8'h05, 8'h05, 8'h00, 5'b10100, 1});
      vt.push_back('{OPC_SHL, 8'h81, 8'h03, 8'h08, 5'b00000, 4});
      vt.push_back('{OPC_SHR, 8'h81, 8'h01, 8'h40, 5'b00100, 2});
      vt.push_back('{OPC_AND, 8'hF0, 8'h3C, 8'h30, 5'b00000, 1});
      vt.push_back('{OPC_OR,  8'h0F, 8'h80, 8'h8F, 5'b01000, 1});
      vt.push_back('{OPC_XOR, 8'hAA, 8'hAA, 8'h00, 5'b10000, 1});
      vt.push_back('{OPC_SUB, 8'h80, 8'h01, 8'h7F, 5'b00110, 1});
      vt.push_back('{OPC_ADD, 8'hFF, 8'h01, 8'h00, 5'b10100, 1});
      vt.push_back('{OPC_SHL, 8'h55, 8'h08, 8'h55, 5'b00000, 1});
      vt.push_back('{OPC_SUB, 8'h00, 8'h01, 8'hFF, 5'b01000, 1});
      vt.push_back('{OPC_SHR, 8'h80, 8'h07, 8'h01, 5'b00000, 8});
      vt.push_back('{OPC_SHL, 8'h40, 8'h02, 8'h00, 5'b10100, 3});
`ifdef ALU_SEQ_MUL_EN
      vt.push_back('{OPC_MUL, 8'h10, 8'h11, 8'h10, 5'b00100, 9});
      vt.push_back('{OPC_MUL, 8'h0F, 8'h0F, 8'hE1, 5'b01000, 9});
`else
      vt.push_back('{OPC_MUL, 8'h10, 8'h11, 8'h00, 5'b10001, 1});
`endif
      vt.push_back('{OPC_XOR, 8'h3C, 8'hFF, 8'hC3, 5'b01000, 1});

      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_result", 32'(result), 32'd0);
      chk("reset_flags", 32'(flg), 32'd0);
      rst_n = 1'b1;

      foreach (vt[i]) issue(vt[i].o, vt[i].va, vt[i].vb, vt[i].res, vt[i].flg, vt[i].lat, 1'b1);
      drain();

      // Held result under backpressure while a competing request is presented.
      out_ready = 1'b0;
      issue(OPC_ADD, 8'h12, 8'h34, 8'h46, 5'b00000, 1, 1'b1);
      t = 0;
      while (!out_valid && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      chk("stall_reach_done", 32'(out_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         op = OPC_XOR;
         a = 8'hFF;
         b = 8'h00;
         @(posedge clk); #1;
         chk("stall_result", 32'(result), 32'h46);
         chk("stall_flags", 32'(flg), 32'd0);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_out_valid", 32'(out_valid), 32'd0);
      chk("release_in_ready", 32'(in_ready), 32'd1);
      drain();

      // Reset during the third EXEC cycle must abort silently.
`ifdef ALU_SEQ_MUL_EN
      issue(OPC_MUL, 8'h10, 8'h11, 8'h00, 5'b00000, 0, 1'b0);
`else
      issue(OPC_SHL, 8'h01, 8'h07, 8'h00, 5'b00000, 0, 1'b0);
`endif
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_exec_busy", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_result", 32'(result), 32'd0);
      chk("abort_flags", 32'(flg), 32'd0);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;

      issue(OPC_ADD, 8'h01, 8'h01, 8'h02, 5'b00000, 1, 1'b1);
      drain();
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal values 4, 8, 16, 32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B; shift amount for SHL/SHR is b[log2(WIDTH)-1:0].
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  operation result.
REQ-012 SHALL have ports flag_zero, flag_neg, flag_carry, flag_ovf, flag_err  output  1 each  status flags.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-014 SHALL capture op, a, b when in_valid && in_ready; input changes after capture are ignored.
REQ-015 ADD/SUB/AND/OR/XOR SHALL skip EXEC: IDLE -> DONE, out_valid asserted 1 cycle after accept.
REQ-016 SUB SHALL compute a + ~b + 1; flag_carry = carry-out (1 = no borrow); ADD flag_carry = carry-out.
REQ-017 flag_ovf SHALL be two's-complement signed overflow for ADD/SUB, 0 for all other ops.
REQ-018 SHL/SHR SHALL shift logically one bit per EXEC cycle for shamt cycles; shamt 0 goes IDLE -> DONE; latency = 1 + shamt.
REQ-019 SHL/SHR flag_carry SHALL be the last bit shifted out; 0 when shamt = 0.
REQ-020 MUL SHALL be iterative shift-add, WIDTH EXEC cycles, latency WIDTH + 1; result = low WIDTH bits of product; flag_carry = 1 iff high WIDTH bits non-zero.
REQ-021 flag_zero SHALL equal (result == 0); flag_neg SHALL equal result[WIDTH-1], for every op.
REQ-022 In DONE, result and all flags SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-023 DONE && out_ready SHALL return to IDLE next cycle with out_valid = 0; no new request accepted in the same cycle.
REQ-024 in_valid while not in IDLE SHALL be ignored and SHALL NOT alter state.

Reset
REQ-025 rst_n = 0 at a clock edge SHALL force IDLE, in_ready = 1, out_valid = 0, result = 0, all flags = 0, from any state including mid-EXEC.
REQ-026 An in-flight operation aborted by reset SHALL produce no output.

Configuration
REQ-027 Macro ALU_SEQ_MUL_EN defined: MUL per REQ-020, flag_err constant 0.
REQ-028 ALU_SEQ_MUL_EN undefined: no multiplier logic; MUL goes IDLE -> DONE, result = 0, flag_zero = 1, other flags 0, flag_err = 1; flag_err = 0 for every other op.

Structure
REQ-029 Package alu_seq_pkg SHALL hold the opcode enum, FSM state enum and opcode localparams.
REQ-030 Flag generation SHALL be one combinational sub-module alu_seq_flags (inputs result, carry, ovf, op; outputs the flags).

Verification (WIDTH = 8)
REQ-031 ADD a=0x7F b=0x01 -> result 0x80, neg=1, ovf=1, carry=0, zero=0, out_valid 1 cycle after accept.
REQ-032 SUB a=0x05 b=0x05 -> result 0x00, zero=1, carry=1, ovf=0.
REQ-033 SHL a=0x81 b=0x03 -> result 0x08, carry=0, out_valid 4 cycles after accept; SHR a=0x81 b=0x01 -> 0x40, carry=1, latency 2.
REQ-034 MUL a=0x10 b=0x11 with macro -> result 0x10, carry=1, latency 9; without macro -> result 0x00, err=1, latency 1.
REQ-035 out_ready held 0 for 5 cycles in DONE with in_valid=1 -> result/flags stable, in_ready=0, request not taken.
REQ-036 rst_n=0 on 3rd EXEC cycle of MUL -> next cycle out_valid=0, in_ready=1, result=0x00, flags 0.
